fifo_flush_ctrl: RTL
====================

# fifo_flush_ctrl

Controller in front of the 4-bit-in / 32-bit-flush FIFO. It round-robin arbitrates two nibble producers onto the single FIFO write port and sequences the multi-cycle flush handshake. It captures the 32-bit flushed word and returns it to the consumer with a one-cycle acknowledge. It also keeps a shadow occupancy count so producers are throttled before the FIFO overflows.

## Interface
- DEPTH, 32, FIFO entry count; full when level = DEPTH-1
- FLUSH_HOLD, 3, cycles fifo_flush_o is held high per flush (minimum 3)
- AUTO_THRESH, 8, level at which an automatic flush fires (only with FIFO_FLUSH_CTRL_AUTO_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_req_i  in  2  per-producer write request
- wr_data0_i  in  4  producer 0 nibble
- wr_data1_i  in  4  producer 1 nibble
- wr_gnt_o  out  2  combinational one-hot grant; data accepted on the edge where the grant is high
- fifo_wr_valid_o  out  1  registered write strobe to FIFO
- fifo_wr_data_o  out  4  registered write nibble
- fifo_full_i  in  1  FIFO full flag (lagging; used as extra throttle)
- fifo_flush_o  out  1  registered flush level to FIFO
- fifo_rd_data_i  in  32  FIFO flush word
- flush_req_i  in  1  consumer flush request (level)
- flush_ack_o  out  1  one-cycle pulse, flush_data_o valid
- flush_data_o  out  32  captured flush word, held until next capture
- flush_auto_o  out  1  qualifies flush_ack_o: 1 = automatic flush
- busy_o  out  1  FSM not in IDLE
- level_o  out  6  shadow occupancy

## Operation
- FSM states: IDLE, HOLD, ACK.
- IDLE -> HOLD when flush_req_i=1 (or auto trigger). fifo_flush_o rises on that edge and the hold counter loads FLUSH_HOLD-1.
- HOLD: fifo_flush_o=1. Counter decrements each cycle. When counter=0, fifo_rd_data_i is captured into flush_data_o, level is updated, and the FSM goes to ACK with fifo_flush_o<=0.
- ACK: flush_ack_o=1 for exactly one cycle, then IDLE. The FSM stays in IDLE for at least one cycle before accepting the next flush, so fifo_flush_o always drops for ≥2 cycles between flushes.
- Arbitration happens only in IDLE. No grant is issued when level=DEPTH-1 or fifo_full_i=1. Round-robin pointer starts at producer 0. A producer that is granted loses priority to the other on the next contention.
- Flush beats write: in the cycle IDLE->HOLD is taken, wr_gnt_o=0.
- Level: +1 per grant (same edge as the registered write). On capture, level ← level>8 ? level-8 : (level>0 ? 1 : 0). This mirrors the FIFO read-pointer rule. Level never exceeds DEPTH-1 and never underflows.
- A flush at level 0 is legal. It completes normally and returns the word the FIFO presents (all 0xC padding).

## Timing
- Write latency: grant at edge N drives fifo_wr_valid_o/fifo_wr_data_o high for cycle N+1 exactly.
- Flush: request sampled at edge T. fifo_flush_o is high for cycles T+1..T+FLUSH_HOLD. Capture happens at edge T+FLUSH_HOLD, while fifo_flush_o is still high. flush_ack_o is high in cycle T+FLUSH_HOLD+1.
- Request-to-ack: FLUSH_HOLD+1 cycles. flush_req_i held across ack starts the next flush no earlier than the edge after the IDLE cycle.
- Reset (asynchronous, any state, including mid-HOLD) values:
  - FSM IDLE; fifo_flush_o=0, flush_ack_o=0, flush_auto_o=0, busy_o=0.
  - wr_gnt_o=0, fifo_wr_valid_o=0, fifo_wr_data_o=0.
  - flush_data_o=0, level_o=0, RR pointer=0.
- Simultaneous both requests with level=DEPTH-2: one grant (RR winner), then no grant until flush.

## Configuration
- FIFO_FLUSH_CTRL_AUTO_EN defined: in IDLE with flush_req_i=0 and level ≥ AUTO_THRESH, an automatic flush starts. It is identical in timing and its ack has flush_auto_o=1. If flush_req_i=1 in the same cycle, the flush is a consumer flush (flush_auto_o=0).
- Not defined: there is no auto trigger, flush_auto_o is tied 0, and AUTO_THRESH is unused.

## Test plan
- Reset mid-HOLD (cycle T+2) -> fifo_flush_o=0, level_o=0, busy_o=0 immediately; no flush_ack_o pulse afterwards.
- Producer 0 writes 1,2,3 (back-to-back); flush_req_i 1 cycle -> fifo_flush_o high 3 cycles; flush_ack_o at T+4; flush_data_o=0xCCCCC321; level_o 3→1.
- Both producers request continuously, data0=0xA, data1=0x5 -> grants alternate 01,10,01…; FIFO receives A,5,A,5; level_o stops at 31 with wr_gnt_o=0.
- Flush at level 0 -> flush_ack_o after 4 cycles, flush_data_o=0xCCCCCCCC, level_o stays 0.
- flush_req_i and wr_req_i=01 in same IDLE cycle -> wr_gnt_o=00, no fifo_wr_valid_o; grant resumes the cycle after ACK.
- With FIFO_FLUSH_CTRL_AUTO_EN, 8 writes and no request -> auto flush; flush_ack_o with flush_auto_o=1; level_o 8→1.

Source files
------------

// File: rtl/fifo_flush_ctrl.sv
// Write arbiter and flush sequencer in front of the 4-bit-in / 32-bit-flush FIFO.
// Optional automatic flush on occupancy is enabled by defining FIFO_FLUSH_CTRL_AUTO_EN.
module fifo_flush_ctrl #(
  parameter int DEPTH       = 32,
  parameter int FLUSH_HOLD  = 3,
  parameter int AUTO_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wr_req_i,
  input  logic [3:0]  wr_data0_i,
  input  logic [3:0]  wr_data1_i,
  output logic [1:0]  wr_gnt_o,
  output logic        fifo_wr_valid_o,
  output logic [3:0]  fifo_wr_data_o,
  input  logic        fifo_full_i,
  output logic        fifo_flush_o,
  input  logic [31:0] fifo_rd_data_i,
  input  logic        flush_req_i,
  output logic        flush_ack_o,
  output logic [31:0] flush_data_o,
  output logic        flush_auto_o,
  output logic        busy_o,
  output logic [5:0]  level_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam int         CNT_W      = $clog2(FLUSH_HOLD);
  localparam logic [5:0] LEVEL_MAX  = 6'(DEPTH - 1);
  localparam logic [5:0] LEVEL_AUTO = 6'(AUTO_THRESH);

`ifdef FIFO_FLUSH_CTRL_AUTO_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  logic [1:0]       state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [5:0]       level_r;
  logic             rr_ptr_r;
  logic             flush_r;
  logic             ack_r;
  logic             auto_pend_r;
  logic             auto_r;
  logic             wr_valid_r;
  logic [3:0]       wr_data_r;
  logic [31:0]      flush_data_r;

  logic             idle_s;
  logic             auto_s;
  logic             start_s;
  logic             can_write_s;
  logic [1:0]       gnt_s;
  logic [3:0]       gnt_data_s;
  logic [5:0]       level_after_flush_s;

  // Flush start decision, round-robin grant and post-flush occupancy
  always_comb begin
    idle_s      = (state_r == ST_IDLE);
    auto_s      = AUTO_EN & ~flush_req_i & (level_r >= LEVEL_AUTO);
    start_s     = idle_s & (flush_req_i | auto_s);
    // A starting flush wins over writes; reset also masks the grant
    can_write_s = reset & idle_s & ~start_s & (level_r != LEVEL_MAX) & ~fifo_full_i;
    gnt_s       = 2'b00;
    if (can_write_s) begin
      case (wr_req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = rr_ptr_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
    gnt_data_s = gnt_s[1] ? wr_data1_i : wr_data0_i;
    if (level_r > 6'd8) begin
      level_after_flush_s = level_r - 6'd8;
    end else if (level_r != 6'd0) begin
      level_after_flush_s = 6'd1;
    end else begin
      level_after_flush_s = 6'd0;
    end
  end

  // Registered FIFO write port and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid_r <= 1'b0;
      wr_data_r  <= 4'd0;
      rr_ptr_r   <= 1'b0;
    end else begin
      wr_valid_r <= |gnt_s;
      if (|gnt_s) begin
        wr_data_r <= gnt_data_s;
        rr_ptr_r  <= gnt_s[0];
      end
    end
  end

  // Flush sequencer, capture register and shadow occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= '0;
      level_r      <= 6'd0;
      flush_r      <= 1'b0;
      ack_r        <= 1'b0;
      auto_pend_r  <= 1'b0;
      auto_r       <= 1'b0;
      flush_data_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_HOLD;
            flush_r     <= 1'b1;
            hold_cnt_r  <= CNT_W'(FLUSH_HOLD - 1);
            auto_pend_r <= auto_s;
          end else if (|gnt_s) begin
            level_r <= level_r + 6'd1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == '0) begin
            flush_data_r <= fifo_rd_data_i;
            level_r      <= level_after_flush_s;
            flush_r      <= 1'b0;
            ack_r        <= 1'b1;
            auto_r       <= auto_pend_r;
            state_r      <= ST_ACK;
          end else begin
            hold_cnt_r <= hold_cnt_r - CNT_W'(1);
          end
        end
        ST_ACK: begin
          ack_r   <= 1'b0;
          auto_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          flush_r <= 1'b0;
          ack_r   <= 1'b0;
          auto_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_gnt_o        = gnt_s;
  assign fifo_wr_valid_o = wr_valid_r;
  assign fifo_wr_data_o  = wr_data_r;
  assign fifo_flush_o    = flush_r;
  assign flush_ack_o     = ack_r;
  assign flush_data_o    = flush_data_r;
  assign flush_auto_o    = auto_r;
  assign busy_o          = (state_r != ST_IDLE);
  assign level_o         = level_r;

endmodule
